tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: the receiving end of the 2:1 mux path. It takes a 1-bit serial line carrying N_CH time slots per frame, marked by a frame-sync strobe, and rebuilds the N_CH parallel channel bits into a registered word with a one-cycle valid pulse. A flywheel sync tracker keeps lock through isolated missing sync strobes and re-aligns on misplaced ones. It sits after the mux/serializer stage and feeds the comparator logic.

## Interface

- N_CH, 2, slots per frame; legal range 2..16.
- MAX_MISS, 2, consecutive missing sync strobes that drop lock; legal range 1..7.
- CW, derived as max(1, clog2(N_CH)), slot counter width (localparam).

- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- din  in  1  serial data, one slot per clock.
- sync  in  1  frame strobe; high during the slot-0 cycle.
- y  out  N_CH  reconstructed frame; y[i] = slot i bit.
- valid  out  1  one-cycle pulse when y is updated.
- sel  out  CW  slot index assigned to the current cycle's din (registered).
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse on a misplaced sync.

## Operation

- State machine with two states, HUNT and LOCKED; miss_cnt is 3 bits; partial-frame shift register is N_CH-1 bits.
- HUNT:
  - sync=0: sel held at 0, no capture.
  - sync=1: din captured as slot 0, sel<=1, state<=LOCKED, miss_cnt<=0.
- LOCKED, each cycle: din stored at index sel, then sel increments and wraps from N_CH-1 to 0.
- Last slot (sel=N_CH-1): y<={din, partial bits}, valid<=1.
- At sel=0 with sync=1: normal frame start, miss_cnt<=0.
- At sel=0 with sync=0 (miss): miss_cnt<=miss_cnt+1 and the frame is processed by flywheel.
  - If miss_cnt+1 == MAX_MISS: state<=HUNT, sel<=0, partial frame discarded, miss_cnt<=0. No valid is produced for this frame.
- At sel≠0 with sync=1 (misplaced): err<=1, partial frame discarded, din captured as slot 0, sel<=1, miss_cnt<=0, stay LOCKED. The current frame produces no valid.
- y holds its value between valid pulses, and also across loss of lock.
- Simultaneous last slot and misplaced sync: the misplaced-sync rule wins. No valid; err=1.

## Timing

- All outputs are registered and update on the rising clk edge.
- Reset: y=0, valid=0, err=0, locked=0, sel=0, state=HUNT, miss_cnt=0, partial=0.
- Reset asserted mid-frame: all of the above on the next edge. The partial frame is lost and no valid is issued.
- Lock latency: sync sampled in HUNT at edge k gives locked=1 after edge k.
- Frame latency: last slot sampled at edge k gives y/valid visible after edge k, with valid low again after edge k+1.
- In steady state, valid pulses every N_CH cycles. The first valid comes N_CH-1 edges after the locking sync edge.
- err is high for exactly the cycle after the misplaced sync edge.
- Loss of lock: locked falls after the edge that samples the MAX_MISS-th consecutive miss.

## Test plan

- Basic framing, N_CH=2, MAX_MISS=2: after reset, sync on every even cycle with din per frame (slot0,slot1) = (1,0),(0,1),(1,1).
  - Required: y = 2'b01, 2'b10, 2'b11.
  - valid pulses every 2 cycles; locked=1 from the edge after the first sync; err stays 0.
- Hunt: din toggling every cycle, sync=0 for 8 cycles after reset.
  - Required: locked=0, valid=0, sel=0, y=0 throughout.
- Flywheel and loss of lock, N_CH=2:
  - One sync omitted, frame (1,1): y=2'b11 is still delivered and locked stays 1.
  - Next sync also omitted: locked drops after that slot-0 edge, no valid for that frame, y keeps 2'b11.
  - A later sync relocks with locked=1 on the following edge.
- Misplaced sync: while locked, assert sync at slot 1 with din=1, then din=0 on the next cycle.
  - Required: err pulses 1 cycle, with no valid for the aborted frame.
  - Next valid arrives one cycle later with y=2'b01.
- Reset mid-frame: assert rst at sel=1.
  - Required: after the edge, y=0, valid=0, locked=0, sel=0, err=0.
  - Relock requires a new sync.
- Width, N_CH=4: sync every 4 cycles with slots 0..3 = 1,0,1,1.
  - Required: y=4'b1101, valid every 4 cycles, sel cycling 1,2,3,0.

Source files
------------

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM serial-to-parallel demultiplexer with flywheel frame-sync tracking
module tdm_demux #(
   parameter int N_CH     = 2,
   parameter int MAX_MISS = 2,
   localparam int CW      = (N_CH > 2) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            din,
   input  logic            sync,
   output logic [N_CH-1:0] y,
   output logic            valid,
   output logic [CW-1:0]   sel,
   output logic            locked,
   output logic            err
);

   typedef enum logic {HUNT, LOCKED} state_t;

   localparam logic [CW-1:0] LAST     = CW'(N_CH - 1);
   localparam logic [2:0]    MISS_LIM = 3'(MAX_MISS);

   state_t          state;
   logic [2:0]      miss_cnt;
   logic [N_CH-2:0] partial;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= HUNT;
         miss_cnt <= '0;
         partial  <= '0;
         y        <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
         locked   <= 1'b0;
         sel      <= '0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         if (state == HUNT) begin
            sel <= '0;
            if (sync) begin
               partial    <= '0;
               partial[0] <= din;
               sel        <= CW'(1);
               miss_cnt   <= '0;
               state      <= LOCKED;
               locked     <= 1'b1;
            end
         end else if (sync && sel != '0) begin
            // Misplaced strobe: the strobe is trusted over the flywheel, restart the frame here.
            err        <= 1'b1;
            partial    <= '0;
            partial[0] <= din;
            sel        <= CW'(1);
            miss_cnt   <= '0;
         end else if (sel == '0 && !sync && (miss_cnt + 3'd1) == MISS_LIM) begin
            state    <= HUNT;
            locked   <= 1'b0;
            sel      <= '0;
            partial  <= '0;
            miss_cnt <= '0;
         end else begin
            if (sel == '0)
               miss_cnt <= sync ? 3'd0 : miss_cnt + 3'd1;
            if (sel == LAST) begin
               y     <= {din, partial};
               valid <= 1'b1;
               sel   <= '0;
            end else begin
               for (int i = 0; i < N_CH - 1; i++)
                  if (sel == CW'(i))
                     partial[i] <= din;
               sel <= sel + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux at N_CH=2 and N_CH=4
module tb_tdm_demux;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din2 = 1'b0, sync2 = 1'b0, din4 = 1'b0, sync4 = 1'b0;
   logic [1:0] y2;
   logic [3:0] y4;
   logic       valid2, valid4, locked2, locked4, err2, err4;
   logic       sel2;
   logic [1:0] sel4;

   always #5 clk = ~clk;

   tdm_demux #(.N_CH(2), .MAX_MISS(2)) dut2 (
      .clk(clk), .rst(rst), .din(din2), .sync(sync2), .y(y2),
      .valid(valid2), .sel(sel2), .locked(locked2), .err(err2));

   tdm_demux #(.N_CH(4), .MAX_MISS(2)) dut4 (
      .clk(clk), .rst(rst), .din(din4), .sync(sync4), .y(y4),
      .valid(valid4), .sel(sel4), .locked(locked4), .err(err4));

   // Reference: a frame is a list of slot bits; position is an integer slot number.
   typedef struct {
      int          n;
      int          maxm;
      bit          lk;
      int          pos;
      int          miss;
      logic [15:0] bits;
      logic [15:0] yv;
      bit          v;
      bit          e;
   } mdl_t;

   typedef struct {
      logic [1:0] y2; bit v2, l2, e2; logic sel2;
      logic [3:0] y4; bit v4, l4, e4; logic [1:0] sel4;
   } rec_t;

   mdl_t m2, m4;
   rec_t cyc_q[$];
   logic [1:0] yq2[$];
   logic [3:0] yq4[$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic mdl_t mstep(mdl_t m, bit r, bit d, bit s);
      m.v = 0;
      m.e = 0;
      if (r) begin
         m.lk = 0; m.pos = 0; m.miss = 0; m.bits = '0; m.yv = '0;
      end else if (!m.lk) begin
         if (s) begin
            m.lk = 1; m.bits = '0; m.bits[0] = d; m.pos = 1; m.miss = 0;
         end
      end else if (s && m.pos != 0) begin
         m.e = 1; m.bits = '0; m.bits[0] = d; m.pos = 1; m.miss = 0;
      end else begin
         bit dropped = 0;
         if (m.pos == 0) begin
            if (s) m.miss = 0;
            else begin
               m.miss++;
               if (m.miss == m.maxm) begin
                  m.lk = 0; m.pos = 0; m.miss = 0; m.bits = '0; dropped = 1;
               end
            end
         end
         if (!dropped) begin
            m.bits[m.pos] = d;
            if (m.pos == m.n - 1) begin
               m.yv = m.bits & ((16'd1 << m.n) - 16'd1);
               m.v = 1;
               m.pos = 0;
            end else m.pos++;
         end
      end
      return m;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(bit r, bit d2, bit s2, bit d4, bit s4);
      rec_t rc;
      rst = r; din2 = d2; sync2 = s2; din4 = d4; sync4 = s4;
      m2 = mstep(m2, r, d2, s2);
      m4 = mstep(m4, r, d4, s4);
      rc.y2 = m2.yv[1:0]; rc.v2 = m2.v; rc.l2 = m2.lk; rc.e2 = m2.e; rc.sel2 = m2.pos[0];
      rc.y4 = m4.yv[3:0]; rc.v4 = m4.v; rc.l4 = m4.lk; rc.e4 = m4.e; rc.sel4 = m4.pos[1:0];
      cyc_q.push_back(rc);
      if (m2.v) yq2.push_back(m2.yv[1:0]);
      if (m4.v) yq4.push_back(m4.yv[3:0]);
      @(posedge clk);
      #2;
   endtask

   int k4 = 0;
   logic [3:0] pat4 = 4'b1101;

   // dut2 gets directed slots; dut4 runs its fixed width frame alongside.
   task automatic step(bit r, bit d2, bit s2);
      drive(r, d2, s2, pat4[k4 % 4], (k4 % 4) == 0);
      k4++;
   endtask

   always begin
      rec_t rc;
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
         rc = cyc_q.pop_front();
         chk("valid2", 16'(valid2), 16'(rc.v2));
         chk("locked2", 16'(locked2), 16'(rc.l2));
         chk("err2", 16'(err2), 16'(rc.e2));
         chk("sel2", 16'(sel2), 16'(rc.sel2));
         chk("y2_hold", 16'(y2), 16'(rc.y2));
         chk("valid4", 16'(valid4), 16'(rc.v4));
         chk("locked4", 16'(locked4), 16'(rc.l4));
         chk("err4", 16'(err4), 16'(rc.e4));
         chk("sel4", 16'(sel4), 16'(rc.sel4));
         chk("y4_hold", 16'(y4), 16'(rc.y4));
      end
      if (valid2 === 1'b1) begin
         if (yq2.size() == 0) chk("y2_frame_unexpected", 16'(y2), 16'hdead);
         else chk("y2_frame", 16'(y2), 16'(yq2.pop_front()));
      end
      if (valid4 === 1'b1) begin
         if (yq4.size() == 0) chk("y4_frame_unexpected", 16'(y4), 16'hdead);
         else chk("y4_frame", 16'(y4), 16'(yq4.pop_front()));
      end
   end

   initial begin
      m2 = '{n: 2, maxm: 2, lk: 0, pos: 0, miss: 0, bits: '0, yv: '0, v: 0, e: 0};
      m4 = '{n: 4, maxm: 2, lk: 0, pos: 0, miss: 0, bits: '0, yv: '0, v: 0, e: 0};
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      // hunt: toggling data, no strobes
      for (int i = 0; i < 8; i++) drive(0, i[0], 0, i[0], 0);
      // basic framing (1,0),(0,1),(1,1)
      step(0, 1, 1); step(0, 0, 0);
      step(0, 0, 1); step(0, 1, 0);
      step(0, 1, 1); step(0, 1, 0);
      // flywheel: one missed strobe, then a second one drops lock
      step(0, 1, 0); step(0, 1, 0);
      step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
      step(0, 1, 1); step(0, 0, 0);
      // misplaced strobe at slot 1, then slot 1 = 0
      step(0, 0, 1); step(0, 1, 1); step(0, 0, 0);
      step(0, 1, 1); step(0, 0, 0);
      // reset mid-frame, then relock
      step(0, 1, 1); step(1, 1, 0);
      step(0, 1, 0); step(0, 0, 0);
      step(0, 1, 1); step(0, 1, 0);
      for (int i = 0; i < 12; i++) step(0, 0, 0);
      // randomized traffic on both instances
      for (int i = 0; i < 800; i++) begin
         bit r, s2, s4;
         r  = ($urandom_range(0, 149) == 0);
         s2 = !m2.lk ? ($urandom_range(0, 2) == 0) :
              (m2.pos == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
         s4 = !m4.lk ? ($urandom_range(0, 2) == 0) :
              (m4.pos == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 24) == 0);
         drive(r, 1'($urandom), s2, 1'($urandom), s4);
      end
      @(posedge clk);
      #3;
      chk("cycle_queue_drained", 16'(cyc_q.size()), 16'd0);
      chk("frame_queue2_drained", 16'(yq2.size()), 16'd0);
      chk("frame_queue4_drained", 16'(yq4.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
